// File: rtl/operand_fetch_if.sv
// Operand-fetch bus bundle: issue request, register-file read/write ports,
// operand bundle output and writeback request.
//   slave  : view used by operand_fetch
//   master : view used by whatever surrounds the block (pipeline + regfile)
interface operand_fetch_if;
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  // Issue request
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_rs;
  logic [AW-1:0] in_rt;
  logic [AW-1:0] in_rd;
  logic          in_rd_we;

  // Register-file read ports (combinational data, same-cycle write bypass)
  logic [AW-1:0] gpr_rd_addr_0;
  logic [AW-1:0] gpr_rd_addr_1;
  logic [DW-1:0] gpr_rd_data_0;
  logic [DW-1:0] gpr_rd_data_1;

  // Register-file write port
  logic          gpr_we;
  logic [AW-1:0] gpr_wr_addr;
  logic [DW-1:0] gpr_wr_data;

  // Operand bundle
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_op0;
  logic [DW-1:0] out_op1;
  logic [AW-1:0] out_rd;
  logic          out_rd_we;

  // Writeback request and sticky error
  logic          wb_valid;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          wb_err;

  modport slave (
    input  in_valid, in_rs, in_rt, in_rd, in_rd_we,
    output in_ready,
    output gpr_rd_addr_0, gpr_rd_addr_1,
    input  gpr_rd_data_0, gpr_rd_data_1,
    output gpr_we, gpr_wr_addr, gpr_wr_data,
    output out_valid, out_op0, out_op1, out_rd, out_rd_we,
    input  out_ready,
    input  wb_valid, wb_addr, wb_data,
    output wb_err
  );

  modport master (
    output in_valid, in_rs, in_rt, in_rd, in_rd_we,
    input  in_ready,
    input  gpr_rd_addr_0, gpr_rd_addr_1,
    output gpr_rd_data_0, gpr_rd_data_1,
    input  gpr_we, gpr_wr_addr, gpr_wr_data,
    input  out_valid, out_op0, out_op1, out_rd, out_rd_we,
    output out_ready,
    output wb_valid, wb_addr, wb_data,
    input  wb_err
  );
endinterface

// File: rtl/operand_fetch.sv
// Operand fetch stage with a per-register pending-write scoreboard.
// Reads both source operands from the register file, stalls on RAW/WAW
// hazards against outstanding writes, and registers writebacks into the
// register-file write port one cycle after they arrive.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset
//   bus  - operand_fetch_if.slave (issue, gpr read/write, bundle, writeback)
module operand_fetch (
  input  logic              clk,
  input  logic              rst,
  operand_fetch_if.slave    bus
);
  localparam int unsigned NREG = 32;
  localparam int unsigned DW   = 32;

  logic [NREG-1:0] pend;
  logic [NREG-1:0] pend_d;
  logic [NREG-1:0] set_vec;
  logic [NREG-1:0] clr_vec;
  logic            hazard;
  logic            accept;
  logic            wb_fire;

  // Register-file read addresses follow the issue request directly
  assign bus.gpr_rd_addr_0 = bus.in_rs;
  assign bus.gpr_rd_addr_1 = bus.in_rt;

  // RAW on either source, WAW on the destination; r0 never hazards
  always_comb begin
    hazard = 1'b0;
    if ((bus.in_rs != '0) && pend[bus.in_rs])
      hazard = 1'b1;
    if ((bus.in_rt != '0) && pend[bus.in_rt])
      hazard = 1'b1;
    if (bus.in_rd_we && (bus.in_rd != '0) && pend[bus.in_rd])
      hazard = 1'b1;
  end

  assign bus.in_ready = (~bus.out_valid | bus.out_ready) & ~hazard;
  assign accept       = bus.in_valid & bus.in_ready;
  assign wb_fire      = bus.wb_valid & (bus.wb_addr != '0);

  // Scoreboard update: a clear retires the write currently on the gpr port,
  // a set from the same edge is applied after it so the set wins
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (accept && bus.in_rd_we && (bus.in_rd != '0))
      set_vec = NREG'(1) << bus.in_rd;
    if (bus.gpr_we)
      clr_vec = NREG'(1) << bus.gpr_wr_addr;
    pend_d    = (pend & ~clr_vec) | set_vec;
    pend_d[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      pend <= '0;
    else
      pend <= pend_d;
  end

  // Operand bundle register: load on accept, drop when consumed, else hold
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.out_valid <= 1'b0;
      bus.out_op0   <= '0;
      bus.out_op1   <= '0;
      bus.out_rd    <= '0;
      bus.out_rd_we <= 1'b0;
    end else if (accept) begin
      bus.out_valid <= 1'b1;
      bus.out_op0   <= (bus.in_rs == '0) ? DW'(0) : bus.gpr_rd_data_0;
      bus.out_op1   <= (bus.in_rt == '0) ? DW'(0) : bus.gpr_rd_data_1;
      bus.out_rd    <= bus.in_rd;
      bus.out_rd_we <= bus.in_rd_we & (bus.in_rd != '0);
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

  // Writeback stage; r0 writes are dropped silently, writes to a register
  // with nothing outstanding still go through but raise the sticky error
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.gpr_we      <= 1'b0;
      bus.gpr_wr_addr <= '0;
      bus.gpr_wr_data <= '0;
      bus.wb_err      <= 1'b0;
    end else begin
      bus.gpr_we <= wb_fire;
      if (wb_fire) begin
        bus.gpr_wr_addr <= bus.wb_addr;
        bus.gpr_wr_data <= bus.wb_data;
        if (!pend[bus.wb_addr])
          bus.wb_err <= 1'b1;
      end
    end
  end
endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have ports (clock and reset first):
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  issue request valid
- in_ready  out  1  issue request accepted when in_valid & in_ready
- in_rs, in_rt  in  5 each  source register addresses
- in_rd  in  5  destination register address
- in_rd_we  in  1  instruction will write in_rd
- gpr_rd_addr_0, gpr_rd_addr_1  out  5 each  register-file read addresses
- gpr_rd_data_0, gpr_rd_data_1  in  32 each  register-file read data; combinational, with same-cycle write bypass
- gpr_we  out  1  register-file write enable
- gpr_wr_addr  out  5  register-file write address
- gpr_wr_data  out  32  register-file write data
- out_valid  out  1  operand bundle valid
- out_ready  in  1  downstream accepts bundle when out_valid & out_ready
- out_op0, out_op1  out  32 each  fetched operands
- out_rd  out  5  forwarded destination address
- out_rd_we  out  1  forwarded destination write flag
- wb_valid  in  1  writeback request; always accepted
- wb_addr  in  5  writeback address
- wb_data  in  32  writeback data
- wb_err  out  1  sticky error flag

Function
REQ-002 SHALL drive gpr_rd_addr_0 = in_rs and gpr_rd_addr_1 = in_rt combinationally at all times.
REQ-003 SHALL hold a 32-bit scoreboard. pend[n]=1 means a write to register n is outstanding. pend[0] SHALL always read 0.
REQ-004 hazard = (in_rs!=0 & pend[in_rs]) | (in_rt!=0 & pend[in_rt]) | (in_rd_we & in_rd!=0 & pend[in_rd]).
REQ-005 in_ready = (~out_valid | out_ready) & ~hazard. It is combinational and SHALL NOT depend on in_valid.
REQ-006 On accept, next edge:
- out_valid <= 1
- out_op0 <= (in_rs==0) ? 0 : gpr_rd_data_0
- out_op1 <= (in_rt==0) ? 0 : gpr_rd_data_1
- out_rd <= in_rd
- out_rd_we <= in_rd_we & (in_rd!=0)
REQ-007 On accept with in_rd_we=1 and in_rd!=0, pend[in_rd] SHALL be set at the same edge. Fetch latency is 1 cycle.
REQ-008 If out_valid & out_ready and there is no accept, out_valid SHALL clear next edge. Otherwise the out_* registers SHALL hold stable while out_valid & ~out_ready.
REQ-009 Writeback is a registered 1-cycle stage. On wb_valid & wb_addr!=0, next edge: gpr_we <= 1, gpr_wr_addr <= wb_addr, gpr_wr_data <= wb_data. Otherwise gpr_we <= 0.
REQ-010 wb_valid with wb_addr==0 SHALL be dropped: no write and no error.
REQ-011 pend[gpr_wr_addr] SHALL clear at the edge ending a cycle in which gpr_we=1.
REQ-012 In a cycle with gpr_we=1, a request whose only hazard is that address SHALL still stall. It is accepted the following cycle.
REQ-013 If a set (REQ-007) and a clear (REQ-011) target the same register at the same edge, the set SHALL win.
REQ-014 wb_valid with wb_addr!=0 and pend[wb_addr]=0 SHALL still be written and SHALL set wb_err. wb_err stays 1 until reset.
REQ-015 The block SHALL never hold more than one outstanding write per register; the WAW stall in REQ-004 enforces this.

Reset
REQ-016 While rst=0, asynchronously:
- pend <= 0
- out_valid, out_rd_we, gpr_we, wb_err <= 0
- out_op0, out_op1, gpr_wr_data <= 0
- out_rd, gpr_wr_addr <= 0
REQ-017 Reset asserted mid-transfer SHALL discard any in-flight bundle and any pending writeback. No register-file write SHALL occur after reset deasserts without a new wb_valid.
REQ-018 in_ready SHALL evaluate per REQ-005 during reset, using reset state values.

Verification
REQ-019 Issue rs=3, rt=4, rd=5, rd_we=1 with regfile r3=0x11, r4=0x22 and out_ready=1 -> next cycle out_valid=1, op0=0x11, op1=0x22, out_rd=5, pend[5]=1.
REQ-020 Next issue rs=5 while pend[5]=1 -> in_ready=0. Then wb_valid, addr=5, data=0xABCD -> gpr_we=1 with addr 5 and data 0xABCD one cycle later. The stalled request is accepted the cycle after that with op0=0xABCD.
REQ-021 Issue rs=0, rt=0, rd=0, rd_we=1 with a nonzero regfile r0 -> op0=op1=0, out_rd_we=0, pend unchanged. wb_valid to addr 0 -> gpr_we stays 0.
REQ-022 Hold out_ready=0 for 3 cycles with out_valid=1 -> in_ready=0 and out_* stable. Raise out_ready with a new request -> back-to-back transfer with no bubble.
REQ-023 wb_valid, addr=7 with pend[7]=0 -> register written, wb_err=1 and remaining 1 until rst pulse.
REQ-024 Assert rst for 1 cycle while out_valid=1, gpr_we=1 and pend=0x0000_00A0 -> immediately out_valid=0, gpr_we=0, pend=0, wb_err=0.
